// File: rtl/req_gnt_rr_arbiter.sv
// ---------------------------------------------------------------------------
// req_gnt_rr_arbiter
// Round-robin arbiter sharing one resource among N requesters over a req/gnt
// handshake. Grants are registered and one-hot. An owner that holds its grant
// for MAX_HOLD cycles has it taken away (signalled by a one-cycle revoke
// pulse). Exactly GAP idle cycles separate consecutive grants.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   req        request vector, bit i = requester i wants the resource
//   gnt        one-hot grant (registered), zero when there is no owner
//   gnt_valid  OR of gnt (registered)
//   gnt_id     index of current owner, 0 when gnt_valid = 0
//   revoke     one-cycle pulse in the cycle after a timeout removed a grant
//   busy       high while a grant is active or the idle gap is running
// ---------------------------------------------------------------------------
module req_gnt_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int GAP      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 revoke,
    output logic                 busy
);

    localparam int ID_W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        COOL  = 2'd2
    } state_t;

    state_t            state_r;
    logic [N-1:0]      gnt_r;
    logic              gnt_valid_r;
    logic [ID_W-1:0]   gnt_id_r;
    logic              revoke_r;
    logic              busy_r;
    logic [7:0]        hold_cnt_r;
    logic [3:0]        gap_cnt_r;
    logic [ID_W-1:0]   last_winner_r;

    logic              pick_valid_s;
    logic [ID_W-1:0]   pick_id_s;
    logic              arb_go_s;
    logic              owner_req_s;

    // Round-robin search: first set request bit after last_winner, wrapping
    // modulo N. Returns {found, index}.
    function automatic logic [ID_W:0] rr_pick(input logic [N-1:0] r,
                                              input logic [ID_W-1:0] lw);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        // Walk from the farthest candidate down so the nearest one wins.
        for (int off = N; off >= 1; off--) begin
            idx = int'(lw) + off;
            if (idx >= N) begin
                idx = idx - N;
            end else begin
                idx = idx;
            end
            if (r[idx]) begin
                res = {1'b1, idx[ID_W-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Arbitration decision and "arbitrate this edge" qualifier.
    always_comb begin
        {pick_valid_s, pick_id_s} = rr_pick(req, last_winner_r);
        // The last edge of the idle gap behaves exactly like IDLE.
        arb_go_s    = (state_r == IDLE) ||
                      ((state_r == COOL) && (gap_cnt_r == 4'd1));
        owner_req_s = req[gnt_id_r];
    end

    // Main state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            gnt_r         <= '0;
            gnt_valid_r   <= 1'b0;
            gnt_id_r      <= '0;
            revoke_r      <= 1'b0;
            busy_r        <= 1'b0;
            hold_cnt_r    <= 8'd0;
            gap_cnt_r     <= 4'd0;
            last_winner_r <= ID_W'(N - 1);
        end else begin
            revoke_r <= 1'b0;
            if (arb_go_s) begin
                gap_cnt_r <= 4'd0;
                if (pick_valid_s) begin
                    state_r     <= GRANT;
                    gnt_r       <= {{(N-1){1'b0}}, 1'b1} << pick_id_s;
                    gnt_valid_r <= 1'b1;
                    gnt_id_r    <= pick_id_s;
                    busy_r      <= 1'b1;
                    hold_cnt_r  <= 8'd1;
                end else begin
                    state_r     <= IDLE;
                    gnt_r       <= '0;
                    gnt_valid_r <= 1'b0;
                    gnt_id_r    <= '0;
                    busy_r      <= 1'b0;
                    hold_cnt_r  <= 8'd0;
                end
            end else begin
                case (state_r)
                    GRANT: begin
                        // Release wins over timeout when both happen at once.
                        if (!owner_req_s || (hold_cnt_r == 8'(MAX_HOLD))) begin
                            state_r       <= COOL;
                            gnt_r         <= '0;
                            gnt_valid_r   <= 1'b0;
                            gnt_id_r      <= '0;
                            busy_r        <= 1'b1;
                            hold_cnt_r    <= 8'd0;
                            gap_cnt_r     <= 4'(GAP);
                            last_winner_r <= gnt_id_r;
                            revoke_r      <= owner_req_s;
                        end else begin
                            hold_cnt_r <= hold_cnt_r + 8'd1;
                        end
                    end
                    COOL: begin
                        gap_cnt_r <= gap_cnt_r - 4'd1;
                    end
                    default: begin
                        state_r     <= IDLE;
                        gnt_r       <= '0;
                        gnt_valid_r <= 1'b0;
                        gnt_id_r    <= '0;
                        busy_r      <= 1'b0;
                        hold_cnt_r  <= 8'd0;
                        gap_cnt_r   <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign gnt       = gnt_r;
    assign gnt_valid = gnt_valid_r;
    assign gnt_id    = gnt_id_r;
    assign revoke    = revoke_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_req_gnt_rr_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for req_gnt_rr_arbiter: directed scenarios followed by random
// request traffic, every cycle compared against a behavioural model that
// tracks owner / hold time / remaining idle gap as plain integers.
// ---------------------------------------------------------------------------
module tb_req_gnt_rr_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int GAP      = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         revoke;
    logic         busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model state
    int m_owner;   // -1 when nobody owns the resource
    int m_held;    // cycles the current owner has held gnt
    int m_cool;    // idle-gap cycles still to elapse
    int m_lw;      // last requester whose grant ended
    bit m_rev;

    req_gnt_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .GAP(GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .revoke    (revoke),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge(input logic rn, input logic [N-1:0] r);
        if (!rn) begin
            m_owner = -1;
            m_held  = 0;
            m_cool  = 0;
            m_lw    = N - 1;
            m_rev   = 1'b0;
        end else begin
            m_rev = 1'b0;
            if (m_owner >= 0) begin
                if (!r[m_owner]) begin
                    m_lw    = m_owner;
                    m_owner = -1;
                    m_cool  = GAP;
                end else if (m_held == MAX_HOLD) begin
                    m_lw    = m_owner;
                    m_owner = -1;
                    m_cool  = GAP;
                    m_rev   = 1'b1;
                end else begin
                    m_held++;
                end
            end else if (m_cool > 1) begin
                m_cool--;
            end else begin
                m_cool = 0;
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_lw + k) % N;
                    if (r[c]) begin
                        m_owner = c;
                        m_held  = 1;
                        break;
                    end
                end
            end
        end
    endtask

    // Apply inputs, clock once, update the model, then compare #1 later.
    task automatic cycle(input logic rn, input logic [N-1:0] r);
        logic [31:0] exp_gnt;
        logic [31:0] exp_id;
        rst_n = rn;
        req   = r;
        @(posedge clk);
        model_edge(rn, r);
        #1;
        exp_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        exp_id  = (m_owner >= 0) ? 32'(m_owner) : 32'd0;
        check_eq("gnt",       32'(gnt),       exp_gnt);
        check_eq("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        check_eq("gnt_id",    32'(gnt_id),    exp_id);
        check_eq("revoke",    32'(revoke),    32'(m_rev));
        check_eq("busy",      32'(busy),      32'((m_owner >= 0) || (m_cool > 0)));
    endtask

    initial begin
        logic [N-1:0] rnd_req;
        m_owner = -1; m_held = 0; m_cool = 0; m_lw = N - 1; m_rev = 1'b0;

        // 1. reset with all requests up
        repeat (3) cycle(1'b0, 4'b1111);

        // 2. single requester, released after 3 grant cycles
        repeat (3) cycle(1'b1, 4'b0001);
        repeat (3) cycle(1'b1, 4'b0000);

        // 3. everyone requesting: rotation with timeouts and revoke pulses
        repeat (45) cycle(1'b1, 4'b1111);
        repeat (3)  cycle(1'b1, 4'b0000);

        // 4. owner 1 releases, 1010 at arbitration -> 3 first, then 1
        repeat (3) cycle(1'b1, 4'b0010);
        cycle(1'b1, 4'b0000);
        repeat (3) cycle(1'b1, 4'b1010);
        repeat (3) cycle(1'b1, 4'b0010);
        repeat (2) cycle(1'b1, 4'b0000);

        // 5. release coincides with the timeout edge: no revoke
        repeat (8) cycle(1'b1, 4'b0100);
        repeat (3) cycle(1'b1, 4'b0000);

        // 6. reset during the 4th cycle of a grant to requester 2
        cycle(1'b1, 4'b0100);
        repeat (3) cycle(1'b1, 4'b1111);
        cycle(1'b0, 4'b1111);
        repeat (4) cycle(1'b1, 4'b1111);

        // Random traffic: requests held for random stretches, rare resets
        rnd_req = 4'b0000;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                rnd_req = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 149) == 0) begin
                cycle(1'b0, rnd_req);
            end else begin
                cycle(1'b1, rnd_req);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
